// File: rtl/spi_slave_regfile_pkg.sv
// Shared definitions for the SPI brightness register slave: field widths,
// chip-select polarity, command codes and FSM state encodings.
package spi_slave_regfile_pkg;

  localparam int DEF_CMD_BITS         = 8;
  localparam int DEF_ADDR_BITS        = 8;
  localparam int DEF_PAYLOAD_BITS     = 8;
  localparam int MASTER_FRAME_WIDTH   = DEF_CMD_BITS + DEF_ADDR_BITS + DEF_PAYLOAD_BITS;
  localparam int DEF_BRIGHTNESS_WIDTH = 7;
  localparam int DEF_NUM_REGS         = 4;

  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_COMMIT  = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-stage synchronizer for an asynchronous pin with registered one-cycle
// rise/fall pulses derived from the synchronized level and its delayed copy.
module spi_sync_edge (
  input  logic sysclk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // Synchronizer chain and edge-pulse registers.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      rise_r  <= sync2_r & ~prev_r;
      fall_r  <= ~sync2_r & prev_r;
    end
  end

  assign level = sync2_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode 0 slave holding a bank of brightness registers; all pins are
// oversampled in sysclk, frames are command/address/payload, MSB first.
module spi_slave_regfile
  import spi_slave_regfile_pkg::*;
#(
  parameter int CMD_BITS         = DEF_CMD_BITS,
  parameter int ADDR_BITS        = DEF_ADDR_BITS,
  parameter int PAYLOAD_BITS     = DEF_PAYLOAD_BITS,
  parameter int FRAME_WIDTH      = MASTER_FRAME_WIDTH,
  parameter int BRIGHTNESS_WIDTH = DEF_BRIGHTNESS_WIDTH,
  parameter int NUM_REGS         = DEF_NUM_REGS
) (
  input  logic                                 sysclk,
  input  logic                                 rst,
  input  logic                                 cs,
  input  logic                                 sclk,
  input  logic                                 mosi,
  output logic                                 miso,
  output logic [NUM_REGS*BRIGHTNESS_WIDTH-1:0] o_brightness,
  output logic                                 o_wr_strobe,
  output logic [ADDR_BITS-1:0]                 o_wr_addr,
  output logic                                 o_frame_err
);

  localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [4:0] CMD_END   = 5'(CMD_BITS - 1);
  localparam logic [4:0] ADDR_END  = 5'(CMD_BITS + ADDR_BITS - 1);
  localparam logic [4:0] FRAME_END = 5'(FRAME_WIDTH - 1);

  logic cs_lvl_s;
  logic cs_fall_s;
  logic cs_rise_unused_s;
  logic sclk_lvl_unused_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic mosi_s;
  logic mosi_rise_unused_s;
  logic mosi_fall_unused_s;

  logic [2:0]                  state_r;
  logic [4:0]                  cnt_r;
  logic [FRAME_WIDTH-1:0]      rx_r;
  logic [PAYLOAD_BITS-1:0]     tx_r;
  logic                        miso_r;
  logic                        strobe_r;
  logic [ADDR_BITS-1:0]        wr_addr_r;
  logic                        err_r;
  logic [BRIGHTNESS_WIDTH-1:0] regs_r [NUM_REGS];

  logic [FRAME_WIDTH-1:0]  rx_next_s;
  logic [CMD_BITS-1:0]     cmd_s;
  logic [ADDR_BITS-1:0]    addr_s;
  logic [ADDR_BITS-1:0]    new_addr_s;
  logic [PAYLOAD_BITS-1:0] tx_load_s;
  logic                    in_frame_s;

  spi_sync_edge u_sync_cs (
    .sysclk (sysclk),
    .rst    (rst),
    .din    (cs),
    .level  (cs_lvl_s),
    .rise   (cs_rise_unused_s),
    .fall   (cs_fall_s)
  );

  spi_sync_edge u_sync_sclk (
    .sysclk (sysclk),
    .rst    (rst),
    .din    (sclk),
    .level  (sclk_lvl_unused_s),
    .rise   (sclk_rise_s),
    .fall   (sclk_fall_s)
  );

  spi_sync_edge u_sync_mosi (
    .sysclk (sysclk),
    .rst    (rst),
    .din    (mosi),
    .level  (mosi_s),
    .rise   (mosi_rise_unused_s),
    .fall   (mosi_fall_unused_s)
  );

  assign rx_next_s  = {rx_r[FRAME_WIDTH-2:0], mosi_s};
  assign cmd_s      = rx_r[FRAME_WIDTH-1 -: CMD_BITS];
  assign addr_s     = rx_r[PAYLOAD_BITS +: ADDR_BITS];
  assign new_addr_s = rx_next_s[ADDR_BITS-1:0];
  assign in_frame_s = (state_r == ST_CMD) || (state_r == ST_ADDR) || (state_r == ST_PAYLOAD);

  // Readback value for the address completed by the current sclk rise.
  always_comb begin
    tx_load_s = '0;
    if (new_addr_s < ADDR_BITS'(NUM_REGS)) begin
      tx_load_s = PAYLOAD_BITS'(regs_r[new_addr_s[IDX_W-1:0]]);
    end else begin
      tx_load_s = '0;
    end
  end

  // Frame FSM, shift registers, register bank and output pulses.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 5'd0;
      rx_r      <= '0;
      tx_r      <= '0;
      miso_r    <= 1'b0;
      strobe_r  <= 1'b0;
      wr_addr_r <= '0;
      err_r     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      strobe_r <= 1'b0;
      err_r    <= 1'b0;
      // Deasserted cs has priority over a coincident sclk rise.
      if (cs_lvl_s == CS_DEASSERT) begin
        err_r   <= in_frame_s;
        state_r <= ST_IDLE;
        cnt_r   <= 5'd0;
        miso_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_r  <= 5'd0;
            miso_r <= 1'b0;
            if (cs_fall_s) begin
              state_r <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              rx_r  <= rx_next_s;
              cnt_r <= cnt_r + 5'd1;
              if (cnt_r == CMD_END) begin
                state_r <= ST_ADDR;
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_s) begin
              rx_r  <= rx_next_s;
              cnt_r <= cnt_r + 5'd1;
              if (cnt_r == ADDR_END) begin
                state_r <= ST_PAYLOAD;
                tx_r    <= tx_load_s;
              end
            end
          end
          ST_PAYLOAD: begin
            if (sclk_rise_s) begin
              rx_r  <= rx_next_s;
              cnt_r <= cnt_r + 5'd1;
              if (cnt_r == FRAME_END) begin
                state_r <= ST_COMMIT;
                miso_r  <= 1'b0;
              end
            end else if (sclk_fall_s) begin
              miso_r <= tx_r[PAYLOAD_BITS-1];
              tx_r   <= {tx_r[PAYLOAD_BITS-2:0], 1'b0};
            end
          end
          ST_COMMIT: begin
            miso_r  <= 1'b0;
            state_r <= ST_DONE;
            if ((cmd_s == CMD_BITS'(CMD_WRITE)) && (addr_s < ADDR_BITS'(NUM_REGS))) begin
              regs_r[addr_s[IDX_W-1:0]] <= rx_r[BRIGHTNESS_WIDTH-1:0];
              strobe_r                  <= 1'b1;
              wr_addr_r                 <= addr_s;
            end
          end
          ST_DONE: begin
            miso_r <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            miso_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign o_brightness[g*BRIGHTNESS_WIDTH +: BRIGHTNESS_WIDTH] = regs_r[g];
  end

  assign miso        = miso_r;
  assign o_wr_strobe = strobe_r;
  assign o_wr_addr   = wr_addr_r;
  assign o_frame_err = err_r;

endmodule
